// File: rtl/hbm_rd_latency_probe.sv
// Passive read-latency probe for one in-order, single-ID HBM AXI read port.
// Each AR handshake is timestamped; the matching RLAST handshake yields a latency and updates running stats.
module hbm_rd_latency_probe #(
    parameter int TS_WIDTH  = 32,
    parameter int DEPTH     = 32,
    parameter int SUM_WIDTH = 48
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     mon_arvalid,
    input  logic                     mon_arready,
    input  logic                     mon_rvalid,
    input  logic                     mon_rready,
    input  logic                     mon_rlast,
    output logic [TS_WIDTH-1:0]      last_lat,
    output logic                     last_valid,
    output logic [31:0]              lat_count,
    output logic [TS_WIDTH-1:0]      lat_min,
    output logic [TS_WIDTH-1:0]      lat_max,
    output logic [SUM_WIDTH-1:0]     lat_sum,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     overflow,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic                meas;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    entry_t                fifo [DEPTH];
    logic [TS_WIDTH-1:0]   ts;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    logic                  ar_hs;
    logic                  rl_hs;
    logic                  do_push;
    logic                  do_pop;
    logic                  ovf_event;
    logic                  perr_event;
    logic                  measured;
    entry_t                head;
    logic [TS_WIDTH-1:0]   lat;
    logic [SUM_WIDTH:0]    sum_ext;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        ar_hs      = mon_arvalid & mon_arready;
        rl_hs      = mon_rvalid & mon_rready & mon_rlast;
        head       = fifo[rd_ptr];
        do_pop     = rl_hs && (outstanding != '0);
        // A pop in the same cycle frees the slot a full-FIFO push needs.
        do_push    = ar_hs && ((outstanding != FULL_CNT) || do_pop);
        ovf_event  = ar_hs && !do_push;
        perr_event = rl_hs && !do_pop;
        lat        = ts - head.ts;
        measured   = do_pop && head.meas && !overflow;
        sum_ext    = {1'b0, lat_sum} + (SUM_WIDTH+1)'(lat);
    end

    // NOTE: the entry storage carries no reset; reset empties the FIFO by clearing the pointers.
    always_ff @(posedge ACLK) begin
        if (do_push)
            fifo[wr_ptr] <= '{meas: enable, ts: ts};
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ts          <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            last_lat    <= '0;
            last_valid  <= 1'b0;
            lat_count   <= '0;
            lat_min     <= '1;
            lat_max     <= '0;
            lat_sum     <= '0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            ts         <= ts + 1'b1;
            last_valid <= do_pop;
            if (do_pop) begin
                last_lat <= lat;
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_push && !do_pop)
                outstanding <= outstanding + 1'b1;
            else if (!do_push && do_pop)
                outstanding <= outstanding - 1'b1;

            // clear takes priority over a coincident measured pop.
            if (clear) begin
                lat_count <= '0;
                lat_min   <= '1;
                lat_max   <= '0;
                lat_sum   <= '0;
            end else if (measured) begin
                if (lat_count != '1)
                    lat_count <= lat_count + 1'b1;
                lat_sum <= sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
                if (lat < lat_min)
                    lat_min <= lat;
                if (lat > lat_max)
                    lat_max <= lat;
            end

            // An error seen in the clear cycle is still recorded.
            overflow  <= (overflow & ~clear) | ovf_event;
            proto_err <= (proto_err & ~clear) | perr_event;
        end
    end

endmodule

// File: tb/tb_hbm_rd_latency_probe.sv
// Bench for hbm_rd_latency_probe: directed scenarios plus random traffic against a queue-based model.
module tb_hbm_rd_latency_probe;

    localparam int TSW = 8;
    localparam int DEP = 4;
    localparam int SW  = 12;
    localparam int TS_MOD  = 256;
    localparam int SUM_MAX = 4095;

    logic            ACLK = 1'b0;
    logic            ARESET, enable, clear;
    logic            mon_arvalid, mon_arready, mon_rvalid, mon_rready, mon_rlast;
    logic [TSW-1:0]  last_lat, lat_min, lat_max;
    logic            last_valid, overflow, proto_err;
    logic [31:0]     lat_count;
    logic [SW-1:0]   lat_sum;
    logic [2:0]      outstanding;

    hbm_rd_latency_probe #(.TS_WIDTH(TSW), .DEPTH(DEP), .SUM_WIDTH(SW)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .clear(clear),
        .mon_arvalid(mon_arvalid), .mon_arready(mon_arready),
        .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast),
        .last_lat(last_lat), .last_valid(last_valid), .lat_count(lat_count),
        .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
        .outstanding(outstanding), .overflow(overflow), .proto_err(proto_err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { int ts; bit meas; } rd_t;
    rd_t     q[$];
    int      m_ts, m_last, m_min, m_max, m_sum;
    longint  m_count;
    bit      m_lv, m_ovf, m_perr;
    int      n_checks = 0;
    int      n_fail   = 0;

    task automatic model_reset();
        q.delete();
        m_ts = 0; m_last = 0; m_lv = 0; m_count = 0;
        m_min = TS_MOD - 1; m_max = 0; m_sum = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic do_reset();
        ARESET = 1; clear = 0; enable = 1;
        mon_arvalid = 0; mon_arready = 0; mon_rvalid = 0; mon_rready = 0; mon_rlast = 0;
        @(posedge ACLK);
        model_reset();
        @(negedge ACLK);
        ARESET = 0;
    endtask

    // Drives one cycle of inputs and advances the model by the same cycle.
    task automatic step(input bit arv, arr, rv, rr, rl, en, clr);
        rd_t e;
        int  lat;
        bit  frozen;
        mon_arvalid = arv; mon_arready = arr;
        mon_rvalid = rv; mon_rready = rr; mon_rlast = rl;
        enable = en; clear = clr;
        @(posedge ACLK);
        frozen = m_ovf;
        m_lv = 0;
        if (clr) begin
            m_count = 0; m_sum = 0; m_max = 0; m_min = TS_MOD - 1; m_ovf = 0; m_perr = 0;
        end
        if (rv && rr && rl) begin
            if (q.size() != 0) begin
                e = q.pop_front();
                lat = (m_ts - e.ts + TS_MOD) % TS_MOD;
                m_last = lat; m_lv = 1;
                if (e.meas && !frozen && !clr) begin
                    if (m_count < 64'hFFFF_FFFF) m_count++;
                    m_sum = (m_sum + lat > SUM_MAX) ? SUM_MAX : m_sum + lat;
                    if (lat < m_min) m_min = lat;
                    if (lat > m_max) m_max = lat;
                end
            end else begin
                m_perr = 1;
            end
        end
        if (arv && arr) begin
            if (q.size() < DEP) q.push_back('{m_ts, en});
            else m_ovf = 1;
        end
        m_ts = (m_ts + 1) % TS_MOD;
        @(negedge ACLK);
    endtask

    task automatic idle();            step(0, 0, 0, 0, 0, 1, 0); endtask
    task automatic ar(input bit en);  step(1, 1, 0, 0, 0, en, 0); endtask
    task automatic rl();              step(0, 0, 1, 1, 1, 1, 0); endtask

    task automatic idle_until(input int t);
        while (m_ts != t) idle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (last_lat !== 8'd0)    begin n_fail++; $display("FAIL reset_last_lat got %0d want 0", last_lat); end
        n_checks++; if (last_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_last_valid got %0b want 0", last_valid); end
        n_checks++; if (lat_count !== 32'd0)  begin n_fail++; $display("FAIL reset_count got %0d want 0", lat_count); end
        n_checks++; if (lat_min !== 8'hFF)    begin n_fail++; $display("FAIL reset_min got %0d want 255", lat_min); end
        n_checks++; if (lat_max !== 8'd0)     begin n_fail++; $display("FAIL reset_max got %0d want 0", lat_max); end
        n_checks++; if (lat_sum !== 12'd0)    begin n_fail++; $display("FAIL reset_sum got %0d want 0", lat_sum); end
        n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        n_checks++; if ({overflow, proto_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {overflow, proto_err}); end
        ar(1); ar(1);
        do_reset();
        n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL midop_reset_outstanding got %0d want 0", outstanding); end
        rl();
        n_checks++; if (proto_err !== 1'b1)   begin n_fail++; $display("FAIL midop_reset_discard got %0b want 1", proto_err); end
    endtask

    task automatic test_single();
        do_reset();
        idle_until(10); ar(1);
        idle_until(35); rl();
        n_checks++; if (last_lat !== 8'd25)   begin n_fail++; $display("FAIL single_last_lat got %0d want 25", last_lat); end
        n_checks++; if (last_valid !== 1'b1)  begin n_fail++; $display("FAIL single_last_valid got %0b want 1", last_valid); end
        n_checks++; if (lat_count !== 32'd1)  begin n_fail++; $display("FAIL single_count got %0d want 1", lat_count); end
        n_checks++; if ({lat_min, lat_max} !== {8'd25, 8'd25}) begin n_fail++; $display("FAIL single_minmax got %0d/%0d want 25/25", lat_min, lat_max); end
        n_checks++; if (lat_sum !== 12'd25)   begin n_fail++; $display("FAIL single_sum got %0d want 25", lat_sum); end
        idle();
        n_checks++; if (last_valid !== 1'b0)  begin n_fail++; $display("FAIL single_strobe_drop got %0b want 0", last_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ar(1); ar(1); ar(1);
        n_checks++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL b2b_outstanding got %0d want 3", outstanding); end
        idle_until(20); rl();
        n_checks++; if (last_lat !== 8'd20)   begin n_fail++; $display("FAIL b2b_lat0 got %0d want 20", last_lat); end
        idle_until(22); rl();
        n_checks++; if (last_lat !== 8'd21)   begin n_fail++; $display("FAIL b2b_lat1 got %0d want 21", last_lat); end
        idle_until(30); rl();
        n_checks++; if (last_lat !== 8'd28)   begin n_fail++; $display("FAIL b2b_lat2 got %0d want 28", last_lat); end
        n_checks++; if (lat_count !== 32'd3)  begin n_fail++; $display("FAIL b2b_count got %0d want 3", lat_count); end
        n_checks++; if ({lat_min, lat_max} !== {8'd20, 8'd28}) begin n_fail++; $display("FAIL b2b_minmax got %0d/%0d want 20/28", lat_min, lat_max); end
        n_checks++; if (lat_sum !== 12'd69)   begin n_fail++; $display("FAIL b2b_sum got %0d want 69", lat_sum); end
        n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL b2b_drained got %0d want 0", outstanding); end
    endtask

    task automatic test_wrap();
        do_reset();
        idle_until(250); ar(1);
        idle_until(4); rl();
        n_checks++; if (last_lat !== 8'd10)   begin n_fail++; $display("FAIL wrap_last_lat got %0d want 10", last_lat); end
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (5) ar(1);
        n_checks++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL ovf_outstanding got %0d want 4", outstanding); end
        rl();
        n_checks++; if ({last_valid, lat_count} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL ovf_frozen got valid=%0b count=%0d want 1/0", last_valid, lat_count); end
        n_checks++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL ovf_pop got %0d want 3", outstanding); end
        step(0, 0, 0, 0, 0, 1, 1);
        n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL ovf_clear got %0b want 0", overflow); end
        ar(1);
        step(1, 1, 1, 1, 1, 1, 0);
        n_checks++; if ({overflow, outstanding} !== {1'b0, 3'd4}) begin n_fail++; $display("FAIL full_push_pop got ovf=%0b out=%0d want 0/4", overflow, outstanding); end
    endtask

    task automatic test_enable_proto();
        do_reset();
        ar(0);
        idle(); rl();
        n_checks++; if ({last_valid, lat_count} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL unmeasured got valid=%0b count=%0d want 1/0", last_valid, lat_count); end
        n_checks++; if (lat_min !== 8'hFF)    begin n_fail++; $display("FAIL unmeasured_min got %0d want 255", lat_min); end
        rl();
        n_checks++; if ({proto_err, last_valid} !== 2'b10) begin n_fail++; $display("FAIL proto_err got %b want 10", {proto_err, last_valid}); end
    endtask

    task automatic test_clear_inflight();
        do_reset();
        ar(1); idle(); idle(); rl();
        ar(1); ar(1);
        step(0, 0, 0, 0, 0, 1, 1);
        n_checks++; if ({lat_count, lat_min} !== {32'd0, 8'hFF}) begin n_fail++; $display("FAIL clear_stats got count=%0d min=%0d want 0/255", lat_count, lat_min); end
        n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL clear_keeps_fifo got %0d want 2", outstanding); end
        idle_until(16); rl();
        idle_until(20); rl();
        n_checks++; if (lat_count !== 32'd2)  begin n_fail++; $display("FAIL clear_count got %0d want 2", lat_count); end
        n_checks++; if ({lat_min, lat_max} !== {8'd12, 8'd15}) begin n_fail++; $display("FAIL clear_minmax got %0d/%0d want 12/15", lat_min, lat_max); end
        n_checks++; if (lat_sum !== 12'd27)   begin n_fail++; $display("FAIL clear_sum got %0d want 27", lat_sum); end
        ar(1); idle();
        step(0, 0, 1, 1, 1, 1, 1);
        n_checks++; if ({lat_count, lat_sum} !== {32'd0, 12'd0}) begin n_fail++; $display("FAIL clear_wins got count=%0d sum=%0d want 0/0", lat_count, lat_sum); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0,
                     $urandom_range(0, 59) == 0);
            end
            n_checks++; if (last_lat !== TSW'(m_last))    begin n_fail++; $display("FAIL rnd_last_lat cyc %0d got %0d want %0d", i, last_lat, m_last); end
            n_checks++; if (last_valid !== m_lv)          begin n_fail++; $display("FAIL rnd_last_valid cyc %0d got %0b want %0b", i, last_valid, m_lv); end
            n_checks++; if (lat_count !== 32'(m_count))   begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, lat_count, m_count); end
            n_checks++; if (lat_min !== TSW'(m_min))      begin n_fail++; $display("FAIL rnd_min cyc %0d got %0d want %0d", i, lat_min, m_min); end
            n_checks++; if (lat_max !== TSW'(m_max))      begin n_fail++; $display("FAIL rnd_max cyc %0d got %0d want %0d", i, lat_max, m_max); end
            n_checks++; if (lat_sum !== SW'(m_sum))       begin n_fail++; $display("FAIL rnd_sum cyc %0d got %0d want %0d", i, lat_sum, m_sum); end
            n_checks++; if (outstanding !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_outstanding cyc %0d got %0d want %0d", i, outstanding, q.size()); end
            n_checks++; if (overflow !== m_ovf)           begin n_fail++; $display("FAIL rnd_overflow cyc %0d got %0b want %0b", i, overflow, m_ovf); end
            n_checks++; if (proto_err !== m_perr)         begin n_fail++; $display("FAIL rnd_proto_err cyc %0d got %0b want %0b", i, proto_err, m_perr); end
        end
    endtask

    initial begin
        ARESET = 1; enable = 0; clear = 0;
        mon_arvalid = 0; mon_arready = 0; mon_rvalid = 0; mon_rready = 0; mon_rlast = 0;
        @(negedge ACLK);
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_overflow();
        test_enable_proto();
        test_clear_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
